// File: rtl/shift_pkg.sv
// ---- shift_pkg : shared encodings for shift_reg_ctrl (rev 1.0) ----
`default_nettype none

package shift_pkg;

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHR  = 2'b01;
   localparam logic [1:0] MODE_SHL  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   localparam logic DIR_SHR = 1'b0;
   localparam logic DIR_SHL = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/shift_reg_ctrl_burst_counter.sv
// ---- burst_counter : loadable down-counter with registered last flag (rev 1.0) ----
`default_nettype none

module burst_counter #(
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          dec,
   output logic          last
);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          last_q, last_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - CW'(1);
      end
      // Flag is computed from the next count so it is valid the cycle cnt==1
      last_d = (cnt_d == CW'(1));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         last_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         last_q <= last_d;
      end
   end

   assign last = last_q;

endmodule

`default_nettype wire

// File: rtl/shift_reg_ctrl.sv
// ---- shift_reg_ctrl : universal shift register with N-step burst shifter (rev 1.0) ----
`default_nettype none

module shift_reg_ctrl
   import shift_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter bit ROTATE = 1'b0,
   parameter int CW     = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin,
   input  logic             start,
   input  logic [CW-1:0]    nshift,
   input  logic             dir,
   output logic [WIDTH-1:0] q,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   localparam logic [CW-1:0] WIDTH_CNT = CW'(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             sout_q, sout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dir_q, dir_d;

   logic             cnt_load, cnt_dec, cnt_last;
   logic [CW-1:0]    cnt_val;
   logic             shr_in, shl_in;
   logic [WIDTH-1:0] shr_q, shl_q;

   burst_counter #(.CW(CW)) u_burst_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .last     (cnt_last)
   );

   always_comb begin
      shr_in = ROTATE ? q_q[0]       : sin;
      shl_in = ROTATE ? q_q[WIDTH-1] : sin;
      shr_q  = {shr_in, q_q[WIDTH-1:1]};
      shl_q  = {q_q[WIDTH-2:0], shl_in};
      // Oversized burst requests saturate at a full-register shift
      cnt_val = (nshift > WIDTH_CNT) ? WIDTH_CNT : nshift;
   end

   always_comb begin
      state_d  = state_q;
      q_d      = q_q;
      sout_d   = sout_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      dir_d    = dir_q;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               dir_d    = dir;
               cnt_load = 1'b1;
               if (cnt_val == '0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = BURST;
                  busy_d  = 1'b1;
               end
            end else if (en) begin
               case (mode)
                  MODE_SHR: begin
                     q_d    = shr_q;
                     sout_d = q_q[0];
                  end
                  MODE_SHL: begin
                     q_d    = shl_q;
                     sout_d = q_q[WIDTH-1];
                  end
                  MODE_LOAD: q_d = d;
                  default:   q_d = q_q;
               endcase
            end
         end
         BURST: begin
            cnt_dec = 1'b1;
            if (dir_q == DIR_SHL) begin
               q_d    = shl_q;
               sout_d = q_q[WIDTH-1];
            end else begin
               q_d    = shr_q;
               sout_d = q_q[0];
            end
            if (cnt_last) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         q_q     <= '0;
         sout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dir_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         sout_q  <= sout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dir_q   <= dir_d;
      end
   end

   assign q    = q_q;
   assign sout = sout_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_reg_ctrl.sv
// ---- tb_shift_reg_ctrl : self-checking bench for shift_reg_ctrl, shift and rotate builds (rev 1.0) ----
`default_nettype none

module tb_shift_reg_ctrl;

   localparam int W  = 8;
   localparam int CW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, en, sin, start, dir;
   logic [1:0]    mode;
   logic [W-1:0]  d;
   logic [CW-1:0] nshift;
   logic [W-1:0]  q0, q1;
   logic          so0, so1, b0, b1, dn0, dn1;

   shift_reg_ctrl #(.WIDTH(W), .ROTATE(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d), .sin(sin),
      .start(start), .nshift(nshift), .dir(dir),
      .q(q0), .sout(so0), .busy(b0), .done(dn0)
   );

   shift_reg_ctrl #(.WIDTH(W), .ROTATE(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d), .sin(sin),
      .start(start), .nshift(nshift), .dir(dir),
      .q(q1), .sout(so1), .busy(b1), .done(dn1)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference model: register contents as plain integers, burst as a count of pending shifts
   logic [W-1:0] mq [2];
   logic         ms [2];
   int           rem;
   logic         mdir, mbusy, mdone;

   function automatic logic [W:0] shf(input logic [W-1:0] v, input logic dr,
                                      input logic s, input bit rot);
      logic         o, b;
      logic [W-1:0] r;
      if (dr) begin
         o = v[W-1];
         b = rot ? o : s;
         r = (v << 1) | W'(b);
      end else begin
         o = v[0];
         b = rot ? o : s;
         r = (v >> 1) | (W'(b) << (W - 1));
      end
      return {o, r};
   endfunction

   task automatic model_edge();
      logic [W:0] t;
      int         n;
      if (!rst_n) begin
         for (int r = 0; r < 2; r++) begin
            mq[r] = '0;
            ms[r] = 1'b0;
         end
         rem = 0; mbusy = 1'b0; mdone = 1'b0;
      end else if (rem > 0) begin
         for (int r = 0; r < 2; r++) begin
            t = shf(mq[r], mdir, sin, r == 1);
            ms[r] = t[W];
            mq[r] = t[W-1:0];
         end
         rem--;
         mbusy = (rem > 0);
         mdone = (rem == 0);
      end else if (mdone) begin
         mdone = 1'b0;
      end else if (start) begin
         n    = (int'(nshift) > W) ? W : int'(nshift);
         mdir = dir;
         if (n == 0) mdone = 1'b1;
         else begin
            rem   = n;
            mbusy = 1'b1;
         end
      end else if (en) begin
         for (int r = 0; r < 2; r++) begin
            if (mode == 2'b01 || mode == 2'b10) begin
               t = shf(mq[r], mode == 2'b10, sin, r == 1);
               ms[r] = t[W];
               mq[r] = t[W-1:0];
            end else if (mode == 2'b11) begin
               mq[r] = d;
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("model_q0",    q0,  mq[0]);
      check("model_q1",    q1,  mq[1]);
      check("model_sout0", so0, ms[0]);
      check("model_sout1", so1, ms[1]);
      check("model_busy0", b0,  mbusy);
      check("model_busy1", b1,  mbusy);
      check("model_done0", dn0, mdone);
      check("model_done1", dn1, mdone);
   endtask

   typedef struct {
      logic          rst_n, en;
      logic [1:0]    mode;
      logic [W-1:0]  d;
      logic          sin, start;
      logic [CW-1:0] nshift;
      logic          dir;
      logic [W-1:0]  q0;
      logic          s0;
      logic [W-1:0]  q1;
      logic          s1, busy, done;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic r, input logic e, input logic [1:0] m,
                               input logic [W-1:0] dd, input logic s, input logic st,
                               input logic [CW-1:0] ns, input logic dr,
                               input logic [W-1:0] eq0, input logic es0,
                               input logic [W-1:0] eq1, input logic es1,
                               input logic eb, input logic ed);
      vec_t v;
      v.rst_n = r;  v.en = e;  v.mode = m;  v.d = dd;  v.sin = s;  v.start = st;
      v.nshift = ns; v.dir = dr; v.q0 = eq0; v.s0 = es0; v.q1 = eq1; v.s1 = es1;
      v.busy = eb; v.done = ed;
      return v;
   endfunction

   initial begin
      rst_n = 1'b0; en = 1'b0; mode = 2'b00; d = '0; sin = 1'b0;
      start = 1'b0; nshift = '0; dir = 1'b0;
      for (int r = 0; r < 2; r++) begin
         mq[r] = '0;
         ms[r] = 1'b0;
      end
      rem = 0; mdir = 1'b0; mbusy = 1'b0; mdone = 1'b0;

      //          rst en md  d     sin st ns  dir  q0    s0 q1    s1 bsy dn
      tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0,  0, 8'h00, 0, 8'h00, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0,  0, 8'h00, 0, 8'h00, 0, 0, 0));
      tbl.push_back(mk(1, 1, 3, 8'hA5, 0, 0, 0,  0, 8'hA5, 0, 8'hA5, 0, 0, 0));
      tbl.push_back(mk(1, 1, 1, 8'h00, 1, 0, 0,  0, 8'hD2, 1, 8'hD2, 1, 0, 0));
      tbl.push_back(mk(1, 1, 2, 8'h00, 0, 0, 0,  0, 8'hA4, 1, 8'hA5, 1, 0, 0));
      tbl.push_back(mk(1, 0, 3, 8'hFF, 0, 0, 0,  0, 8'hA4, 1, 8'hA5, 1, 0, 0));
      tbl.push_back(mk(1, 1, 0, 8'hFF, 0, 0, 0,  0, 8'hA4, 1, 8'hA5, 1, 0, 0));
      tbl.push_back(mk(1, 1, 3, 8'h81, 0, 0, 0,  0, 8'h81, 1, 8'h81, 1, 0, 0));
      tbl.push_back(mk(1, 1, 3, 8'hFF, 0, 1, 3,  1, 8'h81, 1, 8'h81, 1, 1, 0));
      tbl.push_back(mk(1, 1, 3, 8'hFF, 0, 0, 0,  0, 8'h02, 1, 8'h03, 1, 1, 0));
      tbl.push_back(mk(1, 1, 3, 8'hFF, 0, 0, 0,  0, 8'h04, 0, 8'h06, 0, 1, 0));
      tbl.push_back(mk(1, 1, 3, 8'hFF, 0, 0, 0,  0, 8'h08, 0, 8'h0C, 0, 0, 1));
      tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0,  0, 8'h08, 0, 8'h0C, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 0,  0, 8'h08, 0, 8'h0C, 0, 0, 1));
      tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0,  0, 8'h08, 0, 8'h0C, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 8'h00, 1, 1, 15, 0, 8'h08, 0, 8'h0C, 0, 1, 0));
      tbl.push_back(mk(1, 1, 3, 8'h00, 1, 0, 0,  0, 8'h84, 0, 8'h06, 0, 1, 0));
      tbl.push_back(mk(1, 1, 3, 8'h00, 1, 0, 0,  0, 8'hC2, 0, 8'h03, 0, 1, 0));
      tbl.push_back(mk(1, 1, 3, 8'h00, 1, 0, 0,  0, 8'hE1, 0, 8'h81, 1, 1, 0));
      tbl.push_back(mk(1, 1, 3, 8'h00, 1, 0, 0,  0, 8'hF0, 1, 8'hC0, 1, 1, 0));
      tbl.push_back(mk(1, 1, 3, 8'h00, 1, 0, 0,  0, 8'hF8, 0, 8'h60, 0, 1, 0));
      tbl.push_back(mk(1, 1, 3, 8'h00, 1, 0, 0,  0, 8'hFC, 0, 8'h30, 0, 1, 0));
      tbl.push_back(mk(1, 1, 3, 8'h00, 1, 0, 0,  0, 8'hFE, 0, 8'h18, 0, 1, 0));
      tbl.push_back(mk(1, 1, 3, 8'h00, 1, 0, 0,  0, 8'hFF, 0, 8'h0C, 0, 0, 1));
      tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0,  0, 8'hFF, 0, 8'h0C, 0, 0, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         rst_n = tbl[i].rst_n; en = tbl[i].en; mode = tbl[i].mode; d = tbl[i].d;
         sin = tbl[i].sin; start = tbl[i].start; nshift = tbl[i].nshift; dir = tbl[i].dir;
         step();
         check($sformatf("row%0d_q0", i),    q0,  tbl[i].q0);
         check($sformatf("row%0d_sout0", i), so0, tbl[i].s0);
         check($sformatf("row%0d_q1", i),    q1,  tbl[i].q1);
         check($sformatf("row%0d_sout1", i), so1, tbl[i].s1);
         check($sformatf("row%0d_busy", i),  b0,  tbl[i].busy);
         check($sformatf("row%0d_done", i),  dn0, tbl[i].done);
      end

      // Reset in the middle of a 6-step burst
      rst_n = 1'b1; en = 1'b0; start = 1'b1; nshift = 4'd6; dir = 1'b1; sin = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      check("midrst_busy_pre", b0, 1'b1);
      rst_n = 1'b0;
      step();
      check("midrst_q0",   q0, 8'h00);
      check("midrst_q1",   q1, 8'h00);
      check("midrst_busy", b0, 1'b0);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         check("midrst_no_done0", dn0, 1'b0);
         check("midrst_no_done1", dn1, 1'b0);
      end

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         rst_n  = ($urandom_range(0, 59) != 0);
         en     = $urandom_range(0, 1) == 1;
         mode   = 2'($urandom_range(0, 3));
         d      = W'($urandom);
         sin    = $urandom_range(0, 1) == 1;
         start  = ($urandom_range(0, 6) == 0);
         nshift = CW'($urandom_range(0, 15));
         dir    = $urandom_range(0, 1) == 1;
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
